// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_pkg
// Purpose  : Shared FSM state type and default constants for pwm_capture.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int c_def_cnt_w   = 10;
  localparam int c_def_timeout = 1023;
  localparam int c_filt_depth  = 3;

endpackage
`default_nettype wire

// File: rtl/pwm_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : pwm_in_cond
// Purpose  : Synchronizer, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN)
//            and registered edge detect for the PWM input pin.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_in_cond
  import pwm_capture_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_s_d;
  logic r_rise;
  logic r_fall;
  logic w_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [c_filt_depth-2:0] r_hist;
  logic                    r_hold;
  logic [c_filt_depth-1:0] w_win;

  // Level follows the synchronizer only once the whole window agrees.
  assign w_win = {r_hist, r_sync2};
  assign w_s   = ((&w_win) || (~|w_win)) ? r_sync2 : r_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_hold <= 1'b0;
    end else begin
      r_hist <= w_win[c_filt_depth-2:0];
      r_hold <= w_s;
    end
  end
`else
  assign w_s = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  // r_s_d is the level that matches the registered edge strobes in time.
  assign o_s    = r_s_d;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures high time and period of a PWM input, with overflow and
//            stuck-input detection. Optional macro: PWM_CAPTURE_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = c_def_cnt_w,
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             overflow,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] c_max        = '1;
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_quiet_last = CNT_W'(TIMEOUT - 1);

  logic w_s;
  logic w_rise;
  logic w_fall;

  pwm_in_cond u_cond (
    .clk    (clk),
    .rst    (rst),
    .i_pwm  (pwm_in),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_quiet;
  logic [CNT_W-1:0] r_high_out;
  logic [CNT_W-1:0] r_per_out;
  logic             r_valid;
  logic             r_ovf;
  logic             r_stuck;
  logic             r_stuck_lvl;

  logic             w_edge;
  logic             w_timeout;
  logic             w_counting;
  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_high_inc;

  assign w_edge     = w_rise | w_fall;
  // An edge in the timeout cycle wins: the quiet window restarts instead.
  assign w_timeout  = ~w_edge & ~r_stuck & (r_quiet == c_quiet_last);
  assign w_per_inc  = (r_per  == c_max) ? r_per  : r_per  + 1'b1;
  assign w_high_inc = (r_high == c_max) ? r_high : r_high + 1'b1;
  // Cycles where the period counter is asked to advance; high never exceeds it.
  assign w_counting = ~w_timeout &
                      ((r_state == HIGH) || ((r_state == LOW) && !w_rise));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_per       <= '0;
      r_high      <= '0;
      r_quiet     <= '0;
      r_high_out  <= '0;
      r_per_out   <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
      r_stuck     <= 1'b0;
      r_stuck_lvl <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_edge) begin
        r_quiet     <= '0;
        r_stuck     <= 1'b0;
        r_stuck_lvl <= 1'b0;
      end else if (!r_stuck) begin
        r_quiet <= r_quiet + 1'b1;
      end

      if (w_counting && (r_per == c_max)) begin
        r_ovf <= 1'b1;
      end

      if (w_timeout) begin
        r_stuck     <= 1'b1;
        r_stuck_lvl <= w_s;
        r_state     <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state <= HIGH;
              r_per   <= c_one;
              r_high  <= c_one;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_state <= LOW;
              r_per   <= w_per_inc;
            end else begin
              r_per  <= w_per_inc;
              r_high <= w_high_inc;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_state    <= HIGH;
              r_per_out  <= r_per;
              r_high_out <= r_high;
              r_valid    <= 1'b1;
              r_per      <= c_one;
              r_high     <= c_one;
            end else begin
              r_per <= w_per_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign high_cnt    = r_high_out;
  assign period_cnt  = r_per_out;
  assign valid       = r_valid;
  assign overflow    = r_ovf;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_lvl;

endmodule
`default_nettype wire
